pipe_hazard_ctrl: RTL and testbench

Central stall/flush/request controller for the five-stage pipeline. It combines register-dependency hazards (Tuse/Tnew), multiply/divide unit occupancy and exception/interrupt requests into the per-stage control strobes. Those strobes drive the PC, FD_REG, DE_REG, EM_REG and MW_REG `stall`/`flush`/`req` inputs. It owns the only sequential model of MDU occupancy, a down-counter plus FSM, so that HI/LO-dependent instructions are held in D until the result exists.

---
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
//==============================================================================
// pipe_hazard_ctrl_if : hazard inputs from D/E/M and the per-stage strobes back
// Rev 1.0
//==============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic [4:0] E_REG_write_number;
    logic [4:0] M_REG_write_number;
    logic       E_REG_write_enable;
    logic       M_REG_write_enable;
    logic [1:0] E_tnew;
    logic [1:0] M_tnew;
    logic       D_md_use;
    logic       E_md_start;
    logic       E_md_is_div;
    logic       D_eret;
    logic       E_mtc0_epc;
    logic       M_mtc0_epc;
    logic       M_exc_req;
    logic       PC_stall;
    logic       FD_stall;
    logic       DE_flush;
    logic       req;
    logic       md_busy;
    logic [3:0] md_cnt;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse,
        output E_REG_write_number, M_REG_write_number,
        output E_REG_write_enable, M_REG_write_enable,
        output E_tnew, M_tnew,
        output D_md_use, E_md_start, E_md_is_div,
        output D_eret, E_mtc0_epc, M_mtc0_epc, M_exc_req,
        input  PC_stall, FD_stall, DE_flush, req, md_busy, md_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse,
        input  E_REG_write_number, M_REG_write_number,
        input  E_REG_write_enable, M_REG_write_enable,
        input  E_tnew, M_tnew,
        input  D_md_use, E_md_start, E_md_is_div,
        input  D_eret, E_mtc0_epc, M_mtc0_epc, M_exc_req,
        output PC_stall, FD_stall, DE_flush, req, md_busy, md_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//==============================================================================
// pipe_hazard_ctrl : stall/flush/req generation plus MDU occupancy tracking
// Rev 1.0
//==============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t  state;
    logic [3:0] cnt;
    logic       busy;

    logic md_start_eff;
    logic stall_reg;
    logic stall_md;
    logic stall_eret;
    logic stall;

    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wnum,
        input logic       we,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == wnum) && we && (tuse < tnew);
    endfunction

    // A start that coincides with exception entry is squashed along with E.
    assign md_start_eff = bus.E_md_start & ~bus.M_exc_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_eff) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= bus.E_md_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign stall_reg =
        src_hazard(bus.D_rs, bus.D_rs_tuse, bus.E_REG_write_number, bus.E_REG_write_enable, bus.E_tnew) |
        src_hazard(bus.D_rs, bus.D_rs_tuse, bus.M_REG_write_number, bus.M_REG_write_enable, bus.M_tnew) |
        src_hazard(bus.D_rt, bus.D_rt_tuse, bus.E_REG_write_number, bus.E_REG_write_enable, bus.E_tnew) |
        src_hazard(bus.D_rt, bus.D_rt_tuse, bus.M_REG_write_number, bus.M_REG_write_enable, bus.M_tnew);

    assign stall_md   = bus.D_md_use & (busy | bus.E_md_start);
    assign stall_eret = bus.D_eret & (bus.E_mtc0_epc | bus.M_mtc0_epc);
    assign stall      = stall_reg | stall_md | stall_eret;

    // Registers clear on req anyway, so stalling under req would only hold stale state.
    assign bus.req      = bus.M_exc_req;
    assign bus.PC_stall = stall & ~bus.M_exc_req;
    assign bus.FD_stall = stall & ~bus.M_exc_req;
    assign bus.DE_flush = stall & ~bus.M_exc_req;
    assign bus.md_busy  = busy;
    assign bus.md_cnt   = cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================================
// tb_pipe_hazard_ctrl : directed-vector bench for pipe_hazard_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        hz.D_rs = '0;               hz.D_rt = '0;
        hz.D_rs_tuse = 2'd3;        hz.D_rt_tuse = 2'd3;
        hz.E_REG_write_number = '0; hz.M_REG_write_number = '0;
        hz.E_REG_write_enable = 1'b0; hz.M_REG_write_enable = 1'b0;
        hz.E_tnew = '0;             hz.M_tnew = '0;
        hz.D_md_use = 1'b0;         hz.E_md_start = 1'b0;
        hz.E_md_is_div = 1'b0;      hz.D_eret = 1'b0;
        hz.E_mtc0_epc = 1'b0;       hz.M_mtc0_epc = 1'b0;
        hz.M_exc_req = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic s);
        chk({tag, "_pc"}, 32'(hz.PC_stall), 32'(s));
        chk({tag, "_fd"}, 32'(hz.FD_stall), 32'(s));
        chk({tag, "_de"}, 32'(hz.DE_flush), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rst_busy", 32'(hz.md_busy), 32'd0);
        chk("rst_cnt",  32'(hz.md_cnt),  32'd0);
        chk("rst_req",  32'(hz.req),     32'd0);
        chk_strobes("rst", 1'b0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Load-use: lw $5 in E, consumer in D needs rs next cycle.
        hz.E_REG_write_number = 5'd5; hz.E_REG_write_enable = 1'b1; hz.E_tnew = 2'd2;
        hz.D_rs = 5'd5; hz.D_rs_tuse = 2'd1;
        #1;
        chk_strobes("lu_e", 1'b1);
        next_cycle();
        hz.E_REG_write_enable = 1'b0; hz.E_REG_write_number = '0; hz.E_tnew = '0;
        hz.M_REG_write_number = 5'd5; hz.M_REG_write_enable = 1'b1; hz.M_tnew = 2'd1;
        #1;
        chk_strobes("lu_m", 1'b0);
        // rt path against M, tuse 0 < tnew 1
        hz.D_rt = 5'd5; hz.D_rt_tuse = 2'd0;
        #1;
        chk("rt_m", 32'(hz.PC_stall), 32'd1);
        // Both E and M matching
        hz.D_rt_tuse = 2'd3;
        hz.E_REG_write_number = 5'd5; hz.E_REG_write_enable = 1'b1; hz.E_tnew = 2'd2;
        #1;
        chk("both_em", 32'(hz.PC_stall), 32'd1);
        // tuse 3 (unused) never stalls
        hz.D_rs_tuse = 2'd3;
        #1;
        chk("tuse3", 32'(hz.PC_stall), 32'd0);
        clear_inputs();

        // Mult occupancy with an HI/LO reader held in D.
        next_cycle();
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b0; hz.D_md_use = 1'b1;
        #1;
        chk("mul_c0_stall", 32'(hz.PC_stall), 32'd1);
        chk("mul_c0_busy",  32'(hz.md_busy),  32'd0);
        next_cycle();
        hz.E_md_start = 1'b0;
        #1;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("mul_c%0d_cnt", k),   32'(hz.md_cnt),   32'(6 - k));
            chk($sformatf("mul_c%0d_busy", k),  32'(hz.md_busy),  32'd1);
            chk($sformatf("mul_c%0d_stall", k), 32'(hz.PC_stall), 32'd1);
            @(posedge clk);
            #2;
        end
        chk("mul_c6_busy",  32'(hz.md_busy),  32'd0);
        chk("mul_c6_cnt",   32'(hz.md_cnt),   32'd0);
        chk("mul_c6_stall", 32'(hz.PC_stall), 32'd0);
        clear_inputs();

        // Div occupancy.
        next_cycle();
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        next_cycle();
        hz.E_md_start = 1'b0; hz.E_md_is_div = 1'b0;
        #1;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("div_c%0d_busy", k), 32'(hz.md_busy), 32'd1);
            chk($sformatf("div_c%0d_cnt", k),  32'(hz.md_cnt),  32'(11 - k));
            @(posedge clk);
            #2;
        end
        chk("div_c11_busy", 32'(hz.md_busy), 32'd0);

        // req priority over a load-use hazard.
        next_cycle();
        hz.E_REG_write_number = 5'd9; hz.E_REG_write_enable = 1'b1; hz.E_tnew = 2'd2;
        hz.D_rs = 5'd9; hz.D_rs_tuse = 2'd1; hz.M_exc_req = 1'b1;
        #1;
        chk("req_out", 32'(hz.req), 32'd1);
        chk_strobes("req_lu", 1'b0);
        clear_inputs();
        // A start squashed by req leaves the MDU idle.
        hz.E_md_start = 1'b1; hz.M_exc_req = 1'b1;
        next_cycle();
        clear_inputs();
        #1;
        chk("req_md_busy", 32'(hz.md_busy), 32'd0);

        // Asynchronous reset in the middle of a divide.
        next_cycle();
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        chk("rmb_c4_cnt", 32'(hz.md_cnt), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("rmb_busy", 32'(hz.md_busy), 32'd0);
        chk("rmb_cnt",  32'(hz.md_cnt),  32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        hz.D_md_use = 1'b1;
        #1;
        chk("rmb_no_stall", 32'(hz.PC_stall), 32'd0);
        clear_inputs();

        // eret behind mtc0 EPC, and $0 never hazards.
        hz.D_eret = 1'b1; hz.M_mtc0_epc = 1'b1;
        #1;
        chk("eret_m", 32'(hz.PC_stall), 32'd1);
        hz.M_mtc0_epc = 1'b0; hz.E_mtc0_epc = 1'b1;
        #1;
        chk("eret_e", 32'(hz.DE_flush), 32'd1);
        hz.E_mtc0_epc = 1'b0;
        #1;
        chk("eret_none", 32'(hz.PC_stall), 32'd0);
        clear_inputs();
        hz.D_rs = 5'd0; hz.D_rs_tuse = 2'd1;
        hz.E_REG_write_number = 5'd0; hz.E_REG_write_enable = 1'b1; hz.E_tnew = 2'd2;
        #1;
        chk("zero_reg", 32'(hz.PC_stall), 32'd0);
        clear_inputs();

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
